detector_jogada: RTL and testbench



---
 rtl/detector_jogada_pkg.sv | 29 ++
 rtl/detector_jogada_if.sv | 34 +++
 rtl/detector_jogada_sincronizador_2ff.sv | 27 ++
 rtl/detector_jogada.sv | 156 +++++++++++++++
 tb/tb_detector_jogada.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the move detector: FSM state codes, default debounce
// length, one-hot move codes and small bit-counting helpers.
package detector_jogada_pkg;

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      FILTRA      = 3'd1,
      PRESSIONADO = 3'd2,
      SOLTA       = 3'd3,
      EMITE       = 3'd4
   } estado_t;

   localparam int DEBOUNCE_CYCLES_PADRAO = 20;

   localparam logic [3:0] JOGADA_NENHUMA = 4'b0000;
   localparam logic [3:0] JOGADA_0       = 4'b0001;
   localparam logic [3:0] JOGADA_1       = 4'b0010;
   localparam logic [3:0] JOGADA_2       = 4'b0100;
   localparam logic [3:0] JOGADA_3       = 4'b1000;

   function automatic logic eh_one_hot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   function automatic logic [2:0] conta_bits(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// Control-unit <-> move-detector signal bundle. With DETECTOR_JOGADA_ERRO_EN
// defined the bundle also carries the erro_jogada pulse.
interface detector_jogada_if;

   logic       limpa;
   logic       enable;
   logic [3:0] botoes;
   logic [3:0] jogada;
   logic       tem_jogada;
   logic       botao_ativo;
   logic [2:0] db_estado;
`ifdef DETECTOR_JOGADA_ERRO_EN
   logic       erro_jogada;

   modport master (
      output limpa, enable, botoes,
      input  jogada, tem_jogada, botao_ativo, db_estado, erro_jogada
   );
   modport slave (
      input  limpa, enable, botoes,
      output jogada, tem_jogada, botao_ativo, db_estado, erro_jogada
   );
`else
   modport master (
      output limpa, enable, botoes,
      input  jogada, tem_jogada, botao_ativo, db_estado
   );
   modport slave (
      input  limpa, enable, botoes,
      output jogada, tem_jogada, botao_ativo, db_estado
   );
`endif

endinterface

// File: rtl/detector_jogada_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; q lags d by two clocks.
module sincronizador_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] estagio1_r;
   logic [WIDTH-1:0] estagio2_r;

   // Two metastability-settling stages
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estagio1_r <= {WIDTH{1'b0}};
         estagio2_r <= {WIDTH{1'b0}};
      end else begin
         estagio1_r <= d;
         estagio2_r <= estagio1_r;
      end
   end

   assign q = estagio2_r;

endmodule

// File: rtl/detector_jogada.sv
// Debounced single-button move detector: one registered one-hot jogada plus a
// one-cycle tem_jogada per accepted press/release. Option: DETECTOR_JOGADA_ERRO_EN.
module detector_jogada
   import detector_jogada_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO,
   parameter int CNT_W           = 8
) (
   input  logic               clock,
   input  logic               reset,
   detector_jogada_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

   logic [3:0]       botoes_s;
   estado_t          estado_r, estado_prox_s;
   logic [CNT_W-1:0] contador_r, contador_prox_s;
   logic [3:0]       candidato_r, candidato_prox_s;
   logic [3:0]       jogada_r, jogada_prox_s;
   logic             tem_jogada_r;
   logic             botao_ativo_r;

   sincronizador_2ff #(.WIDTH(4)) u_sincronizador (
      .clock (clock),
      .reset (reset),
      .d     (bus.botoes),
      .q     (botoes_s)
   );

   // Next-state, counter, candidate and move selection; limpa overrides the FSM
   always_comb begin
      estado_prox_s    = estado_r;
      contador_prox_s  = contador_r;
      candidato_prox_s = candidato_r;
      jogada_prox_s    = jogada_r;

      case (estado_r)
         OCIOSO: begin
            if (bus.enable && eh_one_hot(botoes_s)) begin
               candidato_prox_s = botoes_s;
               contador_prox_s  = {CNT_W{1'b0}};
               estado_prox_s    = FILTRA;
            end else begin
               estado_prox_s = OCIOSO;
            end
         end
         FILTRA: begin
            if ((botoes_s != candidato_r) || !bus.enable) begin
               estado_prox_s = OCIOSO;
            end else if (contador_r == CNT_FIM) begin
               estado_prox_s = PRESSIONADO;
            end else begin
               contador_prox_s = contador_r + CNT_UM;
            end
         end
         PRESSIONADO: begin
            // Once accepted, extra buttons and enable no longer matter
            if (botoes_s == 4'b0000) begin
               contador_prox_s = {CNT_W{1'b0}};
               estado_prox_s   = SOLTA;
            end else begin
               estado_prox_s = PRESSIONADO;
            end
         end
         SOLTA: begin
            if (botoes_s != 4'b0000) begin
               estado_prox_s = PRESSIONADO;
            end else if (contador_r == CNT_FIM) begin
               jogada_prox_s = candidato_r;
               estado_prox_s = EMITE;
            end else begin
               contador_prox_s = contador_r + CNT_UM;
            end
         end
         EMITE: begin
            estado_prox_s = OCIOSO;
         end
         default: begin
            estado_prox_s = OCIOSO;
         end
      endcase

      if (bus.limpa) begin
         estado_prox_s   = OCIOSO;
         contador_prox_s = {CNT_W{1'b0}};
         jogada_prox_s   = JOGADA_NENHUMA;
      end else begin
         estado_prox_s = estado_prox_s;
      end
   end

   // State registers; Moore outputs registered from the next state so they
   // line up exactly with the state they decode
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_r      <= OCIOSO;
         contador_r    <= {CNT_W{1'b0}};
         candidato_r   <= JOGADA_NENHUMA;
         jogada_r      <= JOGADA_NENHUMA;
         tem_jogada_r  <= 1'b0;
         botao_ativo_r <= 1'b0;
      end else begin
         estado_r      <= estado_prox_s;
         contador_r    <= contador_prox_s;
         candidato_r   <= candidato_prox_s;
         jogada_r      <= jogada_prox_s;
         tem_jogada_r  <= (estado_prox_s == EMITE);
         botao_ativo_r <= (estado_prox_s == PRESSIONADO) || (estado_prox_s == SOLTA);
      end
   end

   assign bus.jogada      = jogada_r;
   assign bus.tem_jogada  = tem_jogada_r;
   assign bus.botao_ativo = botao_ativo_r;
   assign bus.db_estado   = estado_r;

`ifdef DETECTOR_JOGADA_ERRO_EN
   logic cond_erro_s;
   logic erro_r;
   logic multi_retido_r;

   // Multi-press detection: idle multi-hot, or a foreign button while held
   always_comb begin
      cond_erro_s = 1'b0;
      if ((estado_r == OCIOSO) && bus.enable) begin
         cond_erro_s = (conta_bits(botoes_s) >= 3'd2);
      end else if (estado_r == PRESSIONADO) begin
         cond_erro_s = ((botoes_s & ~candidato_r) != 4'b0000);
      end else begin
         cond_erro_s = 1'b0;
      end
   end

   // One pulse per continuous multi-press; the hold flag clears on full release
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         erro_r         <= 1'b0;
         multi_retido_r <= 1'b0;
      end else begin
         erro_r <= cond_erro_s && !multi_retido_r && !bus.limpa;
         if (botoes_s == 4'b0000) begin
            multi_retido_r <= 1'b0;
         end else if (cond_erro_s) begin
            multi_retido_r <= 1'b1;
         end else begin
            multi_retido_r <= multi_retido_r;
         end
      end
   end

   assign bus.erro_jogada = erro_r;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada (DEBOUNCE_CYCLES=4): directed
// scenarios followed by randomized presses checked against a latency model.
module tb_detector_jogada;

   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   int         tests = 0;
   int         fails = 0;
   int         pulses = 0;
   int         erros = 0;
   logic [3:0] jogada_modelo;
   logic [3:0] multi_tab [11];

   detector_jogada_if bus();

   detector_jogada #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Apply botoes for one rising edge, then settle 1 time unit past the edge
   task automatic cyc(input logic [3:0] b);
      bus.botoes = b;
      @(posedge clock);
      #1;
      if (bus.tem_jogada === 1'b1) pulses++;
`ifdef DETECTOR_JOGADA_ERRO_EN
      if (bus.erro_jogada === 1'b1) erros++;
`endif
   endtask

   initial begin
      logic [3:0] btn;
      logic       ok;
      int         nb, h, r;

      multi_tab = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100,
                    4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1111};
      bus.limpa  = 1'b0;
      bus.enable = 1'b1;
      bus.botoes = 4'b0000;
      #1;
      check("reset_jogada", 8'(bus.jogada), 8'h00);
      check("reset_tem", 8'(bus.tem_jogada), 8'h00);
      check("reset_ativo", 8'(bus.botao_ativo), 8'h00);
      check("reset_estado", 8'(bus.db_estado), 8'h00);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // 1: asynchronous reset while a press is held
      for (int k = 0; k < 10; k++) cyc(4'b0100);
      check("t1_ativo_antes", 8'(bus.botao_ativo), 8'h01);
      check("t1_estado_antes", 8'(bus.db_estado), 8'h02);
      #2 reset = 1'b1;
      #1;
      check("t1_async_jogada", 8'(bus.jogada), 8'h00);
      check("t1_async_tem", 8'(bus.tem_jogada), 8'h00);
      check("t1_async_ativo", 8'(bus.botao_ativo), 8'h00);
      check("t1_async_estado", 8'(bus.db_estado), 8'h00);
      bus.botoes = 4'b0000;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 12; k++) cyc(4'b0000);
      check("t1_sem_pulso", 8'(pulses), 8'h00);

      // 2: clean press of 0010, exact latencies
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc(4'b0010);
         if (k == D + 2) check("t2_ativo_cedo", 8'(bus.botao_ativo), 8'h00);
         if (k == D + 3) check("t2_ativo_sobe", 8'(bus.botao_ativo), 8'h01);
      end
      for (int k = 1; k <= 12; k++) begin
         cyc(4'b0000);
         check("t2_tem", 8'(bus.tem_jogada), {7'd0, (k == D + 3)});
         if (k == D + 3) check("t2_jogada_pulso", 8'(bus.jogada), 8'h02);
      end
      check("t2_pulsos", 8'(pulses), 8'h01);
      check("t2_jogada_final", 8'(bus.jogada), 8'h02);

      // 3: bounces on press and release
      pulses = 0;
      for (int r2 = 0; r2 < 2; r2++) begin
         cyc(4'b1000); cyc(4'b1000); cyc(4'b0000); cyc(4'b0000);
      end
      for (int k = 0; k < 10; k++) cyc(4'b1000);
      cyc(4'b0000); cyc(4'b0000); cyc(4'b1000); cyc(4'b1000);
      for (int k = 0; k < 12; k++) cyc(4'b0000);
      check("t3_pulsos", 8'(pulses), 8'h01);
      check("t3_jogada", 8'(bus.jogada), 8'h08);

      // 4: two-button press is rejected
      pulses = 0;
      erros  = 0;
      for (int k = 0; k < 10; k++) cyc(4'b0011);
      for (int k = 0; k < 12; k++) cyc(4'b0000);
      check("t4_pulsos", 8'(pulses), 8'h00);
      check("t4_jogada", 8'(bus.jogada), 8'h08);
`ifdef DETECTOR_JOGADA_ERRO_EN
      check("t4_erros", 8'(erros), 8'h01);
`endif

      // 5: enable gating, then accepted once enabled while held
      pulses = 0;
      bus.enable = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc(4'b0001);
         check("t5_estado_ocioso", 8'(bus.db_estado), 8'h00);
      end
      bus.enable = 1'b1;
      for (int k = 0; k < 10; k++) cyc(4'b0001);
      check("t5_ativo", 8'(bus.botao_ativo), 8'h01);
      for (int k = 0; k < 12; k++) cyc(4'b0000);
      check("t5_pulsos", 8'(pulses), 8'h01);
      check("t5_jogada", 8'(bus.jogada), 8'h01);

      // 6: limpa on the edge that would enter EMITE
      pulses = 0;
      for (int k = 0; k < 10; k++) cyc(4'b0100);
      for (int k = 1; k <= D + 2; k++) cyc(4'b0000);
      check("t6_estado_solta", 8'(bus.db_estado), 8'h03);
      bus.limpa = 1'b1;
      cyc(4'b0000);
      check("t6_tem", 8'(bus.tem_jogada), 8'h00);
      check("t6_jogada", 8'(bus.jogada), 8'h00);
      check("t6_estado", 8'(bus.db_estado), 8'h00);
      bus.limpa = 1'b0;
      for (int k = 0; k < 5; k++) cyc(4'b0000);
      check("t6_pulsos", 8'(pulses), 8'h00);
      check("t6_jogada_final", 8'(bus.jogada), 8'h00);

      // Randomized presses against the latency model
      jogada_modelo = 4'b0000;
      for (int t = 0; t < 16; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            btn = multi_tab[$urandom_range(0, 10)];
         end else begin
            btn = 4'b0001 << $urandom_range(0, 3);
         end
         ok = ($countones(btn) == 1);
         nb = $urandom_range(0, 2);
         for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(1, 2)) begin
               cyc(btn);
               check("rnd_quique_tem", 8'(bus.tem_jogada), 8'h00);
               check("rnd_quique_ativo", 8'(bus.botao_ativo), 8'h00);
            end
            repeat ($urandom_range(1, 2)) begin
               cyc(4'b0000);
               check("rnd_quique_tem", 8'(bus.tem_jogada), 8'h00);
               check("rnd_quique_ativo", 8'(bus.botao_ativo), 8'h00);
            end
         end
         h = D + 3 + $urandom_range(0, 6);
         for (int k = 1; k <= h; k++) begin
            cyc(btn);
            check("rnd_press_tem", 8'(bus.tem_jogada), 8'h00);
            check("rnd_press_ativo", 8'(bus.botao_ativo), {7'd0, ok && (k >= D + 3)});
         end
         r = D + 4 + $urandom_range(0, 4);
         for (int k = 1; k <= r; k++) begin
            cyc(4'b0000);
            if (ok && (k == D + 3)) jogada_modelo = btn;
            check("rnd_solta_tem", 8'(bus.tem_jogada), {7'd0, ok && (k == D + 3)});
            check("rnd_solta_ativo", 8'(bus.botao_ativo), {7'd0, ok && (k <= D + 2)});
         end
         check("rnd_jogada", 8'(bus.jogada), 8'(jogada_modelo));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
